uart_tx_arb: RTL and testbench

Round-robin packet arbiter that shares one UART transmit byte stream between `N_REQ` independent byte-stream requesters. The arbiter sits in the `pclk` domain in front of an `axi_uart` TX FIFO write port, and its output handshake connects to that port. A grant is held for a whole packet, so packets from different requesters never interleave. A stall watchdog keeps a hung requester from locking the UART.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arb_rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 138 +++++++++++++
 tb/tb_uart_tx_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
// Optional header byte support is selected with the UART_ARB_HDR_EN macro.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_MARK = 4'hA;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// `start`, wrapping modulo N_REQ.
import uart_arb_pkg::*;

module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int GW    = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    start,
    output logic [GW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(start) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = GW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter sharing one UART TX byte stream among N_REQ
// requesters, with a stall watchdog. Define UART_ARB_HDR_EN to prefix packets
// with the header byte {4'hA, id}.
//
// state | meaning
// IDLE  | no owner; round-robin pick when any requester is valid
// HDR   | header byte offered, held until out_ready (UART_ARB_HDR_EN only)
// DATA  | owner's bytes passed through until last or watchdog expiry
import uart_arb_pkg::*;

module uart_tx_arb #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 1024,
    localparam int GW      = grant_w(N_REQ)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][7:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic [GW-1:0]         grant,
    output logic                  busy,
    output logic                  tout_pulse
);

    localparam int             TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TC_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  LAST_IDX = GW'(N_REQ - 1);

    arb_state_t    state;
    logic [GW-1:0] last_grant;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] start;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          xfer;

    assign start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
    assign xfer  = (state == DATA) && req_valid[grant] && out_ready;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req_valid),
        .start (start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef UART_ARB_HDR_EN
    logic [3:0] gid;

    always_comb begin
        gid         = '0;
        gid[GW-1:0] = grant;
    end
`endif

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        req_ready = '0;
        case (state)
`ifdef UART_ARB_HDR_EN
            HDR: begin
                out_valid = 1'b1;
                out_data  = {HDR_MARK, gid};
            end
`endif
            DATA: begin
                out_valid        = req_valid[grant];
                out_data         = req_data[grant];
                req_ready[grant] = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_IDX;
            tcnt       <= '0;
            busy       <= 1'b0;
            tout_pulse <= 1'b0;
        end else begin
            tout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        tcnt       <= '0;
                        busy       <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        state      <= HDR;
`else
                        state      <= DATA;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                HDR: begin
                    if (out_ready) begin
                        state <= DATA;
                        tcnt  <= '0;
                    end
                end
`endif
                DATA: begin
                    // a transfer in the expiry cycle takes priority over the timeout
                    if (xfer) begin
                        tcnt <= '0;
                        if (req_last[grant]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tcnt == TC_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        tout_pulse <= 1'b1;
                        tcnt       <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a per-cycle vector table for plain round-robin
// traffic plus directed sequences for stalls, watchdog, pacing and reset.
module tb_uart_tx_arb;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [3:0]      req_valid, req_last;
    logic [3:0][7:0] req_data;
    logic            out_ready;

    logic [3:0] req_ready, req_ready8;
    logic       out_valid, out_valid8;
    logic [7:0] out_data, out_data8;
    logic [1:0] grant, grant8;
    logic       busy, busy8, tout_pulse, tout_pulse8;

    always #5 pclk = ~pclk;

    uart_tx_arb #(.N_REQ(4), .TIMEOUT(1024)) dut (
        .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .grant(grant), .busy(busy),
        .tout_pulse(tout_pulse)
    );

    uart_tx_arb #(.N_REQ(4), .TIMEOUT(8)) dut8 (
        .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready8), .out_valid(out_valid8),
        .out_data(out_data8), .out_ready(out_ready), .grant(grant8), .busy(busy8),
        .tout_pulse(tout_pulse8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // requester sources: byte memories advanced on accepted handshakes
    logic [7:0] smem  [4][8];
    logic       slast [4][8];
    int         slen  [4];
    int         sptr  [4];
    logic [3:0] sen;
    logic       sel8;

    // monitor state (main instance)
    int         cyc = 0;
    int         tout_cnt = 0;
    logic [7:0] cap[$];
    int         tq[$];

    always @(posedge pclk) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) cap.push_back(out_data);
        if (tout_pulse) tout_cnt = tout_cnt + 1;
        if (req_valid[0] && req_ready[0]) tq.push_back(cyc);
    end

    typedef struct {
        logic       orr;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] er;
        logic [1:0] eg;
        logic       eb;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic v, input logic [7:0] d, input logic [3:0] r,
                                       input logic [1:0] g, input logic b);
        return {16'd0, v, v ? d : 8'h00, r, g, b};
    endfunction

    task automatic add(input logic orr, input logic ev, input logic [7:0] ed,
                       input logic [3:0] er, input logic [1:0] eg, input logic eb);
        vec_t v;
        v.orr = orr; v.ev = ev; v.ed = ed; v.er = er; v.eg = eg; v.eb = eb;
        tv.push_back(v);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (sen[i] && sptr[i] < slen[i]) begin
                req_valid[i] = 1'b1;
                req_data[i]  = smem[i][sptr[i]];
                req_last[i]  = slast[i][sptr[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = 8'h00;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            slen[i] = 0;
            sptr[i] = 0;
        end
        sen = 4'b0000;
    endtask

    task automatic load(input int i, input logic [7:0] base, input int n, input int plen);
        for (int k = 0; k < n; k++) begin
            smem[i][k]  = base + 8'(k);
            slast[i][k] = (plen > 0) && ((k % plen) == plen - 1);
        end
        slen[i] = n;
        sptr[i] = 0;
        sen[i]  = 1'b1;
    endtask

    task automatic step();
        logic [3:0] hs;
        hs = (sel8 ? req_ready8 : req_ready) & req_valid;
        @(posedge pclk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) sptr[i]++;
        drive();
        #1;
    endtask

    task automatic do_reset();
        presetn   = 1'b0;
        out_ready = 1'b1;
        clear_src();
        drive();
        #1;
        presetn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         order[5] = '{0, 1, 2, 3, 0};
        int         base, guard, gp, kb, t0;
        logic [7:0] e[$];

        sel8      = 1'b0;
        presetn   = 1'b0;
        out_ready = 1'b1;
        clear_src();
        drive();
        #3;
        chk("reset_main", 32'({out_valid, req_ready, busy, tout_pulse, grant}), 32'h0);
        chk("reset_t8", 32'({out_valid8, req_ready8, busy8, tout_pulse8, grant8}), 32'h0);
        #1;
        presetn = 1'b1;
        #1;

        // ---- test 1: all requesters, 2-byte packets, grants 0,1,2,3,0 ----
        for (int p = 0; p < 5; p++) begin
            gp = (p == 0) ? 0 : order[p-1];
            kb = (p == 4) ? 2 : 0;
            add(1'b1, 1'b0, 8'h00, 4'h0, 2'(gp), 1'b0);
`ifdef UART_ARB_HDR_EN
            add(1'b1, 1'b1, {4'hA, 2'b00, 2'(order[p])}, 4'h0, 2'(order[p]), 1'b1);
`endif
            add(1'b1, 1'b1, 8'(16 * order[p] + kb),     4'(1 << order[p]), 2'(order[p]), 1'b1);
            add(1'b1, 1'b1, 8'(16 * order[p] + kb + 1), 4'(1 << order[p]), 2'(order[p]), 1'b1);
        end
        add(1'b1, 1'b0, 8'h00, 4'h0, 2'd0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 4'h0, 2'd0, 1'b0);

        do_reset();
        load(0, 8'h00, 4, 2);
        load(1, 8'h10, 2, 2);
        load(2, 8'h20, 2, 2);
        load(3, 8'h30, 2, 2);
        for (int k = 0; k < tv.size(); k++) begin
            out_ready = tv[k].orr;
            settle();
            chk($sformatf("t1_vec%0d", k), pk(out_valid, out_data, req_ready, grant, busy),
                pk(tv[k].ev, tv[k].ed, tv[k].er, tv[k].eg, tv[k].eb));
            step();
        end

        // ---- test 2: requester 3 stalls mid-packet, requester 1 must wait ----
        do_reset();
        base = cap.size();
        load(3, 8'h30, 3, 3);
        load(1, 8'h10, 3, 3);
        sen[1] = 1'b0;
        settle();
        guard = 0;
        while (sptr[3] < 2 && guard < 40) begin step(); guard++; end
        chk("t2_reach", 32'(sptr[3]), 32'd2);
        sen[3] = 1'b0;
        sen[1] = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold", 32'({grant, req_ready[1], out_valid, busy}), 32'({2'd3, 1'b0, 1'b0, 1'b1}));
            step();
        end
        sen[3] = 1'b1;
        settle();
`ifdef UART_ARB_HDR_EN
        e = '{8'hA3, 8'h30, 8'h31, 8'h32, 8'hA1, 8'h10, 8'h11, 8'h12};
`else
        e = '{8'h30, 8'h31, 8'h32, 8'h10, 8'h11, 8'h12};
`endif
        guard = 0;
        while (cap.size() - base < e.size() && guard < 60) begin step(); guard++; end
        chk("t2_count", 32'(cap.size() - base), 32'(e.size()));
        for (int k = 0; k < e.size(); k++)
            if (base + k < cap.size()) chk($sformatf("t2_byte%0d", k), 32'(cap[base+k]), 32'(e[k]));

        // ---- test 3: out_ready stalls in HDR and DATA ----
        do_reset();
        base = cap.size();
        t0   = tout_cnt;
        load(0, 8'h40, 3, 3);
        out_ready = 1'b0;
        settle();
        step();
`ifdef UART_ARB_HDR_EN
        for (int k = 0; k < 20; k++) begin
            chk("t3_hdr_hold", 32'({out_valid, out_data, req_ready}), 32'({1'b1, 8'hA0, 4'h0}));
            step();
        end
        out_ready = 1'b1;
        settle();
        step();
        out_ready = 1'b0;
        settle();
`endif
        for (int k = 0; k < 20; k++) begin
            chk("t3_data_hold", 32'({out_valid, out_data, req_ready}), 32'({1'b1, 8'h40, 4'h0}));
            step();
        end
        out_ready = 1'b1;
        settle();
`ifdef UART_ARB_HDR_EN
        e = '{8'hA0, 8'h40, 8'h41, 8'h42};
`else
        e = '{8'h40, 8'h41, 8'h42};
`endif
        guard = 0;
        while (cap.size() - base < e.size() && guard < 40) begin step(); guard++; end
        for (int k = 0; k < 4; k++) step();
        chk("t3_count", 32'(cap.size() - base), 32'(e.size()));
        for (int k = 0; k < e.size(); k++)
            if (base + k < cap.size()) chk($sformatf("t3_byte%0d", k), 32'(cap[base+k]), 32'(e[k]));
        chk("t3_no_tout", 32'(tout_cnt - t0), 32'd0);

        // ---- test 4: watchdog on the TIMEOUT=8 instance ----
        sel8 = 1'b1;
        do_reset();
        load(2, 8'h20, 2, 0);
        load(3, 8'h30, 1, 1);
        settle();
        guard = 0;
        while (sptr[2] < 2 && guard < 40) begin step(); guard++; end
        chk("t4_reach", 32'(sptr[2]), 32'd2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4_wait%0d", k), 32'({busy8, tout_pulse8, grant8}), 32'({1'b1, 1'b0, 2'd2}));
            step();
        end
        chk("t4_tout", 32'({busy8, tout_pulse8}), 32'({1'b0, 1'b1}));
        step();
`ifdef UART_ARB_HDR_EN
        chk("t4_regrant", 32'({grant8, out_valid8, out_data8, tout_pulse8}), 32'({2'd3, 1'b1, 8'hA3, 1'b0}));
`else
        chk("t4_regrant", 32'({grant8, out_valid8, out_data8, tout_pulse8}), 32'({2'd3, 1'b1, 8'h30, 1'b0}));
`endif
        sel8 = 1'b0;

        // ---- test 5: back-to-back single-byte packets from requester 0 ----
        do_reset();
        base = tq.size();
        load(0, 8'h50, 4, 1);
        settle();
        guard = 0;
        while (tq.size() - base < 4 && guard < 40) begin step(); guard++; end
        chk("t5_count", 32'(tq.size() - base), 32'd4);
        for (int k = 1; k < 4; k++)
            if (base + k < tq.size())
`ifdef UART_ARB_HDR_EN
                chk($sformatf("t5_gap%0d", k), 32'(tq[base+k] - tq[base+k-1]), 32'd3);
`else
                chk($sformatf("t5_gap%0d", k), 32'(tq[base+k] - tq[base+k-1]), 32'd2);
`endif

        // ---- test 6: asynchronous reset mid-packet ----
        do_reset();
        load(1, 8'h60, 3, 3);
        settle();
        guard = 0;
        while (sptr[1] < 1 && guard < 40) begin step(); guard++; end
        chk("t6_mid", 32'({busy, grant, out_valid}), 32'({1'b1, 2'd1, 1'b1}));
        #2;
        presetn = 1'b0;
        #1;
        chk("t6_async", 32'({out_valid, req_ready, busy, tout_pulse, grant}), 32'h0);
        clear_src();
        load(0, 8'h70, 1, 1);
        load(3, 8'h73, 1, 1);
        presetn = 1'b1;
        settle();
        chk("t6_idle", 32'({out_valid, busy}), 32'h0);
        step();
`ifdef UART_ARB_HDR_EN
        chk("t6_first", 32'({grant, busy, out_valid, out_data}), 32'({2'd0, 1'b1, 1'b1, 8'hA0}));
`else
        chk("t6_first", 32'({grant, busy, out_valid, out_data}), 32'({2'd0, 1'b1, 1'b1, 8'h70}));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
